// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state, entry layout, word size.
// Latency: none (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, word} entries; flush empties it and beats push/pop.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push ignored while full, pop ignored while empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic         push,
    input  fetch_entry_t pushData,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];

    logic doPush;
    logic doPop;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign doPush = push && !full && !flush;
    assign doPop  = pop && !empty && !flush;
    assign head   = mem_q[rdPtr_q];

    // Pointer/occupancy next state; flush resets everything to empty.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PW'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
            count_d = count_q + CW'(doPush) - CW'(doPop);
        end
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between pointers, so no reset.
    always_ff @(posedge clock) begin
        if (doPush) mem_q[wrPtr_q] <= pushData;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one word request at a time, buffers words.
// Latency: memAck in cycle N gives instrValid in N+1; one instruction per cycle sustained.
// Backpressure: instrReady low fills the queue, after which memReq drops until a pop.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetN,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    output logic [31:0] instruction,
    output logic [31:0] instrPc,
    input  logic        instrReady
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetchPc_q, fetchPc_d;
    logic [31:0]  staleAddr_q, staleAddr_d;

    logic         queueFull;
    logic         queueEmpty;
    fetch_entry_t queueHead;
    fetch_entry_t pushEntry;
    logic         accept;
    logic         popHead;
    logic         enterFlush;

    // A response only counts when it answers a live (non-stale) request.
    assign accept     = (state_q == REQ) && memReq && memAck && !redirect;
    assign popHead    = !queueEmpty && instrReady && !redirect;
    // Redirect with a request still outstanding: its response must be swallowed.
    assign enterFlush = (state_q == REQ) && redirect && memReq && !memAck;
    assign pushEntry  = '{pc: fetchPc_q, word: memData};

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock    (clock),
        .resetN   (resetN),
        .push     (accept),
        .pushData (pushEntry),
        .pop      (popHead),
        .flush    (redirect),
        .full     (queueFull),
        .empty    (queueEmpty),
        .head     (queueHead)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: leave IDLE at once, park in FLUSH until the stale ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (enterFlush) state_d = FLUSH;
            FLUSH:   if (memAck) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: request is held on the stale address while flushing.
    always_comb begin
        memReq  = 1'b0;
        memAddr = fetchPc_q;
        case (state_q)
            REQ: begin
                memReq  = !queueFull;
                memAddr = fetchPc_q;
            end
            FLUSH: begin
                memReq  = 1'b1;
                memAddr = staleAddr_q;
            end
            default: begin
                memReq  = 1'b0;
                memAddr = fetchPc_q;
            end
        endcase
    end

    // Fetch PC and stale address next state.
    always_comb begin
        fetchPc_d   = fetchPc_q;
        staleAddr_d = staleAddr_q;
        if (redirect)    fetchPc_d = redirectPc;
        else if (accept) fetchPc_d = fetchPc_q + 32'(INSTR_BYTES);
        if (enterFlush)  staleAddr_d = fetchPc_q;
    end

    // Fetch PC and stale address registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fetchPc_q   <= RESET_PC;
            staleAddr_q <= RESET_PC;
        end else begin
            fetchPc_q   <= fetchPc_d;
            staleAddr_q <= staleAddr_d;
        end
    end

    assign instrValid  = !queueEmpty;
    assign instruction = queueHead.word;
    assign instrPc     = queueHead.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        resetN;
    logic        memReq, memAck, redirect, instrValid, instrReady;
    logic [31:0] memAddr, memData, redirectPc, instruction, instrPc;
    logic        memReq2, memAck2, instrValid2, instrReady2, redirect2;
    logic [31:0] memAddr2, memData2, redirectPc2, instruction2, instrPc2;

    always #5 clock = ~clock;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .resetN(resetN), .memReq(memReq), .memAddr(memAddr),
        .memAck(memAck), .memData(memData), .redirect(redirect), .redirectPc(redirectPc),
        .instrValid(instrValid), .instruction(instruction), .instrPc(instrPc),
        .instrReady(instrReady)
    );

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clock(clock), .resetN(resetN), .memReq(memReq2), .memAddr(memAddr2),
        .memAck(memAck2), .memData(memData2), .redirect(redirect2), .redirectPc(redirectPc2),
        .instrValid(instrValid2), .instruction(instruction2), .instrPc(instrPc2),
        .instrReady(instrReady2)
    );

    int nassert = 0;
    int nfail   = 0;

    // Reference model: started (left reset), stale request pending, queue of entries.
    bit           started;
    bit           stale;
    logic [31:0]  m_pc;
    logic [31:0]  m_stale;
    fetch_entry_t mq[$];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic bit m_req();
        return started && (stale || (mq.size() < DEPTH));
    endfunction

    function automatic logic [31:0] m_addr();
        return stale ? m_stale : m_pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nassert++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        started = 1'b0;
        stale   = 1'b0;
        m_pc    = 32'h0000_0000;
        m_stale = 32'h0000_0000;
        mq.delete();
    endtask

    task automatic model_step(input bit ack, input bit rdy, input bit redir, input logic [31:0] rpc);
        bit           req;
        fetch_entry_t tmp;
        req = m_req();
        if (!started) begin
            started = 1'b1;
            if (redir) m_pc = rpc;
        end else if (redir) begin
            if (!stale && req && !ack) begin
                stale   = 1'b1;
                m_stale = m_pc;
            end else if (stale && ack) begin
                stale = 1'b0;
            end
            mq.delete();
            m_pc = rpc;
        end else begin
            if (mq.size() > 0 && rdy) tmp = mq.pop_front();
            if (stale) begin
                if (ack) stale = 1'b0;
            end else if (req && ack) begin
                mq.push_back('{pc: m_pc, word: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        chk("memReq", 32'(memReq), 32'(m_req()));
        if (m_req()) chk("memAddr", memAddr, m_addr());
        chk("instrValid", 32'(instrValid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("instruction", instruction, mq[0].word);
            chk("instrPc", instrPc, mq[0].pc);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, check next falling edge.
    task automatic tick(input bit ack, input bit rdy, input bit redir, input logic [31:0] rpc);
        logic [31:0] dat;
        dat = m_req() ? mem_word(m_addr()) : $urandom();
        memAck     = ack;
        memData    = dat;
        instrReady = rdy;
        redirect   = redir;
        redirectPc = rpc;
        memData2   = memAddr2;
        model_step(ack, rdy, redir, rpc);
        @(negedge clock);
        compare();
    endtask

    initial begin
        resetN = 1'b0;
        memAck = 1'b0; memData = '0; redirect = 1'b0; redirectPc = '0; instrReady = 1'b0;
        memAck2 = 1'b1; memData2 = '0; redirect2 = 1'b0; redirectPc2 = '0; instrReady2 = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset memReq", 32'(memReq), 32'd0);
        chk("reset instrValid", 32'(instrValid), 32'd0);
        chk("reset memReq wrap", 32'(memReq2), 32'd0);
        resetN = 1'b1;

        // Continuous acks, always ready: stream 0,4,8,12; wrap instance FFF8,FFFC,0.
        tick(1, 1, 0, 0);
        chk("first req", 32'(memReq), 32'd1);
        chk("first addr", memAddr, 32'h0);
        chk("wrap first addr", memAddr2, 32'hFFFF_FFF8);
        tick(1, 1, 0, 0);
        chk("stream pc0", instrPc, 32'h0);
        chk("wrap pc0", instrPc2, 32'hFFFF_FFF8);
        tick(1, 1, 0, 0);
        chk("stream pc1", instrPc, 32'h4);
        chk("wrap pc1", instrPc2, 32'hFFFF_FFFC);
        tick(1, 1, 0, 0);
        chk("stream pc2", instrPc, 32'h8);
        chk("wrap pc2", instrPc2, 32'h0);
        tick(1, 1, 0, 0);
        chk("stream pc3", instrPc, 32'hC);
        memAck2 = 1'b0;

        // Fill to full with instrReady low, then drain.
        tick(1, 1, 1, 32'h0);
        chk("redir ack valid", 32'(instrValid), 32'd0);
        chk("redir ack addr", memAddr, 32'h0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        chk("full memReq", 32'(memReq), 32'd0);
        chk("full head", instrPc, 32'h0);
        tick(1, 0, 0, 0);
        chk("full ack ignored", 32'(memReq), 32'd0);
        tick(0, 1, 0, 0);
        chk("drain pc4", instrPc, 32'h4);
        chk("reassert req", 32'(memReq), 32'd1);
        chk("reassert addr", memAddr, 32'h10);
        tick(0, 1, 0, 0);
        chk("drain pc8", instrPc, 32'h8);
        tick(0, 1, 0, 0);
        chk("drain pc12", instrPc, 32'hC);
        tick(0, 1, 0, 0);
        chk("drained", 32'(instrValid), 32'd0);

        // Redirect with 0x10 outstanding: flush until its ack.
        tick(0, 1, 1, 32'h40);
        chk("flush addr", memAddr, 32'h10);
        chk("flush valid", 32'(instrValid), 32'd0);
        tick(0, 1, 0, 0);
        chk("flush hold", memAddr, 32'h10);
        tick(1, 1, 0, 0);
        chk("post flush addr", memAddr, 32'h40);
        chk("stale dropped", 32'(instrValid), 32'd0);
        tick(1, 1, 0, 0);
        chk("post flush pc", instrPc, 32'h40);

        // Redirect coinciding with the ack for 0x20, two entries queued.
        tick(1, 1, 1, 32'h18);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("two queued addr", memAddr, 32'h20);
        tick(1, 0, 1, 32'h80);
        chk("redir same ack valid", 32'(instrValid), 32'd0);
        chk("redir same ack addr", memAddr, 32'h80);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        chk("three queued", instrPc, 32'h80);
        #2 resetN = 1'b0;
        #1;
        chk("async memReq", 32'(memReq), 32'd0);
        chk("async instrValid", 32'(instrValid), 32'd0);
        model_reset();
        @(negedge clock);
        resetN = 1'b1;
        tick(1, 1, 0, 0);
        chk("restart addr", memAddr, 32'h0);
        tick(1, 1, 0, 0);
        chk("restart pc", instrPc, 32'h0);

        // Randomized traffic against the model.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                bit          a, r, d;
                logic [31:0] p;
                a = m_req() ? ($urandom() % 3 != 0) : ($urandom() % 8 == 0);
                r = ($urandom() % 8) < (2 + 2 * ph);
                d = ($urandom() % 20) == 0;
                p = ($urandom() % 4 == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
                tick(a, r, d, p);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream fetch stage for the single-cycle `DataPath`. It owns the fetch PC and issues one-at-a-time word requests to instruction memory. Returned words are buffered with their PCs in a small prefetch queue, and the head entry is presented to the datapath under a valid/ready handshake. A branch/jump redirect from the datapath flushes the queue and discards any in-flight memory response.

## Interface
Parameters:
- `DEPTH`, 4, prefetch queue entries; power of two, ≥ 2
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clock`  in  1  single clock, rising edge
- `resetN`  in  1  asynchronous, active-low reset
- `memReq`  out  1  request valid to instruction memory
- `memAddr`  out  32  word address of the request; held stable while `memReq`=1 and no `memAck`
- `memAck`  in  1  one-cycle pulse: `memData` holds the word for the current request
- `memData`  in  32  instruction word, valid only with `memAck`
- `redirect`  in  1  one-cycle pulse: taken branch/jump
- `redirectPc`  in  32  new fetch address, valid with `redirect`
- `instrValid`  out  1  queue head valid
- `instruction`  out  32  queue head word
- `instrPc`  out  32  PC of queue head (datapath `pcQ`)
- `instrReady`  in  1  datapath consumes head this cycle

## Operation
- Registers: `fetchPc`, `staleAddr`, `state`, queue (`count`, head/tail pointers, {pc, word} entries).
- States:
  - IDLE: reset state; `memReq`=0; always → REQ on the next edge.
  - REQ: `memReq = (count != DEPTH)`, `memAddr = fetchPc`.
  - FLUSH: `memReq`=1, `memAddr = staleAddr`; on `memAck` the data is dropped → REQ.
- Accepted response (REQ, `memAck`, no `redirect`): push {`fetchPc`, `memData`}, `fetchPc += 4`. Wraps 32'hFFFF_FFFC → 32'h0000_0000.
- `redirect` (any state):
  - Queue cleared (`count`←0). Any same-cycle push or pop is suppressed.
  - `fetchPc`←`redirectPc`.
  - If state=REQ, `memReq`=1 and `memAck`=0: `staleAddr`←`fetchPc`, state → FLUSH.
  - If `memAck`=1 in the same cycle: the word is dropped and state stays REQ.
  - A redirect in FLUSH: update `fetchPc` only and remain in FLUSH.
- Pop: `instrValid && instrReady && !redirect`. Push and pop in the same cycle: `count` unchanged.
- Full: `memReq` deasserts. A pending request cannot exist while full, because only an ack pushes. This guarantees request stability.
- Empty: `instrValid`=0, and `instruction`/`instrPc` are don't-care.
- A `memAck` while `memReq`=0 is ignored.

## Timing
- Reset (async assert, any cycle including mid-request): `state`=IDLE, `fetchPc`=`RESET_PC`, `count`=0, `memReq`=0, `instrValid`=0. A pending memory response after reset is ignored, since `memReq`=0 in IDLE.
- First request: `memReq`=1 with `memAddr`=`RESET_PC` in the second cycle after `resetN` rises.
- Fetch latency: `memAck` in cycle N → entry visible (`instrValid`=1) in cycle N+1.
- Throughput: one instruction per cycle when `memAck` arrives every cycle and `instrReady`=1.
- Redirect in cycle N:
  - `instrValid`=0 in N+1.
  - Request for `redirectPc` in N+1 if no response was in flight.
  - Otherwise the request is issued the cycle after the stale ack.
- All outputs derive from registers, except `memReq`/`memAddr`, which are combinational from `state`, `count`, `fetchPc` and `staleAddr` (no input-to-output paths).

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {IDLE, REQ, FLUSH}
  - `INSTR_BYTES`=4
  - `fetch_entry_t` struct {pc[31:0], word[31:0]}
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`, parameter `DEPTH`. Ports: push, pop, flush, full, empty, head. Flush has priority over push/pop.
- The top level holds the FSM, `fetchPc`, `staleAddr` and the output muxing.

## Test plan
- Reset release, memory acks every cycle, `instrReady`=1 → `instrPc` sequence 0, 4, 8, 12 on consecutive cycles, starting 3 cycles after `resetN` rises.
- `instrReady`=0, acks continuous, `DEPTH`=4 → exactly 4 pushes, `memReq`=0 while full. Raising `instrReady` then drains 0, 4, 8, 12 and `memReq` reasserts after the first pop.
- Request at 0x10 un-acked, `redirect` with `redirectPc`=0x40 → `memAddr` stays 0x10 (FLUSH). The ack word for 0x10 is never output; the next `memAddr` is 0x40 and the first `instrPc` is 0x40.
- `redirect` (to 0x80) in the same cycle as `memAck` for 0x20 with 2 queued entries → `instrValid`=0 next cycle, no FLUSH, next request address 0x80.
- `RESET_PC`=32'hFFFF_FFF8, continuous acks → `instrPc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `resetN` pulsed low mid-request with the queue holding 3 entries → `instrValid`=0 and `memReq`=0 immediately (asynchronously). After release, fetching restarts at `RESET_PC`.
